// File: rtl/ifmap_read_addr_gen_if.sv
// Handshake/bus bundle between the IFMAP read address generator and its environment.
// Latency: none, wires only.
// Backpressure: rd_ready from the consumer; full tells the writer to stall.
interface ifmap_read_addr_gen_if #(
    parameter int WIDTH = 5
) ();
    logic             start;
    logic [WIDTH-1:0] ifmap_len;
    logic             wr_en;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_addr;
    logic             rd_valid;
    logic             window_last;
    logic             done;
    logic             full;
    logic [WIDTH-1:0] occupancy;
    logic             ovf;

    // Environment side: drives row control, writer strobe and consumer ready.
    modport master (
        output start, ifmap_len, wr_en, rd_ready,
        input  rd_addr, rd_valid, window_last, done, full, occupancy, ovf
    );

    // Generator side.
    modport slave (
        input  start, ifmap_len, wr_en, rd_ready,
        output rd_addr, rd_valid, window_last, done, full, occupancy, ovf
    );
endinterface

// File: rtl/ifmap_read_addr_gen.sv
// IFMAP circular-scratchpad read address generator: sliding 1-D window walk, occupancy tracking, entry release.
// Latency: start -> first rd_valid is 2 cycles minimum; one WAIT cycle between windows; done 1 cycle after last handshake.
// Backpressure: rd_ready=0 holds rd_addr/rd_valid/window_last; full stalls the writer. Optional IFMAP_RD_OVF_EN adds sticky ovf.
module ifmap_read_addr_gen #(
    parameter int DEPTH     = 11,
    parameter int WIDTH     = 5,
    parameter int FILT_SIZE = 3,
    parameter int STRIDE    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ifmap_read_addr_gen_if.slave bus
);
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] F_W     = WIDTH'(FILT_SIZE);
    localparam logic [WIDTH-1:0] S_W     = WIDTH'(STRIDE);

    typedef enum logic [1:0] {IDLE, WAIT, READ, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] offset_q, offset_d;
    logic [WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic [WIDTH-1:0] occ_q, occ_d;
    // Entries of the row still lying beyond the current window start + FILT_SIZE.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] release_amt;
    logic [WIDTH-1:0] need;
    logic             full;
    logic             push;
    logic             hs;
    logic             final_win;

    // Circular add; both operands are below DEPTH so one subtract suffices.
    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, DEPTH_W}) begin
            s = s - {1'b0, DEPTH_W};
        end
        return s[WIDTH-1:0];
    endfunction

    assign full      = (occ_q == DEPTH_W);
    assign push      = bus.wr_en & ~full;
    assign hs        = bus.rd_valid & bus.rd_ready;
    // The final window is the one after which no further STRIDE step fits.
    assign final_win = (rem_q < S_W);
    // The final window also releases the trailing remainder, so wait until that
    // is present too; occupancy can then never underflow.
    assign need      = final_win ? (F_W + rem_q) : F_W;

    assign bus.rd_addr     = wrap_add(base_q, offset_q);
    assign bus.rd_valid    = (state_q == READ);
    assign bus.window_last = (state_q == READ) && (offset_q == F_W - 1'b1);
    assign bus.done        = (state_q == DONE);
    assign bus.full        = full;
    assign bus.occupancy   = occ_q;

    // Next-state logic: window walk, release amount and base advance.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        offset_d    = offset_q;
        win_cnt_d   = win_cnt_q;
        rem_d       = rem_q;
        release_amt = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && (bus.ifmap_len >= F_W)) begin
                    state_d   = WAIT;
                    rem_d     = bus.ifmap_len - F_W;
                    offset_d  = '0;
                    win_cnt_d = '0;
                end
            end
            WAIT: begin
                if (occ_q >= need) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (hs) begin
                    if (offset_q == F_W - 1'b1) begin
                        offset_d  = '0;
                        win_cnt_d = win_cnt_q + 1'b1;
                        if (final_win) begin
                            release_amt = F_W + rem_q;
                            state_d     = DONE;
                        end else begin
                            release_amt = S_W;
                            rem_d       = rem_q - S_W;
                            state_d     = WAIT;
                        end
                        base_d = wrap_add(base_q, release_amt);
                    end else begin
                        offset_d = offset_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        occ_d = occ_q + {{(WIDTH-1){1'b0}}, push} - release_amt;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            offset_q  <= '0;
            win_cnt_q <= '0;
            occ_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            offset_q  <= offset_d;
            win_cnt_q <= win_cnt_d;
            occ_q     <= occ_d;
            rem_q     <= rem_d;
        end
    end

`ifdef IFMAP_RD_OVF_EN
    logic ovf_q;

    // Sticky flag: a push attempted while full was dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (bus.wr_en && full) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule
